commit_trace_sched: RTL

- Synthesizable commit-trace scheduler between the commit stage and an on-chip trace sink (trace encoder / debug buffer).
- Each cycle, collects up to NR_COMMIT_PORTS retired instructions plus one exception and serializes them in program order into a buffer.
- Drains the buffer one record per cycle over a valid/ready interface.
- Never back-pressures commit: on lack of space it drops whole cycles, counts the losses, and later inserts a GAP marker.

---
 rtl/commit_trace_sched_pkg.sv | 35 +++
 rtl/commit_trace_sched_if.sv | 22 ++
 rtl/commit_trace_sched_fifo.sv | 61 ++++++
 rtl/commit_trace_sched.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/commit_trace_sched_pkg.sv
// Shared types for the commit-trace scheduler: record layout, record kinds,
// scheduler states and the architectural constants the formatter needs.
package trace_pkg;

  localparam int VLEN  = 64;
  localparam int SEQ_W = 16;

  // mcause value of an ebreak; these are swallowed while the core is in debug mode
  localparam logic [63:0] BREAKPOINT_CAUSE = 64'd3;

  typedef enum logic [1:0] {
    COMMIT    = 2'd0,
    EXCEPTION = 2'd1,
    GAP       = 2'd2
  } trace_kind_e;

  typedef struct packed {
    trace_kind_e      kind;
    logic [SEQ_W-1:0] seq;
    logic [1:0]       priv;
    logic             dbg;
    logic [VLEN-1:0]  pc;
    logic [31:0]      instr;
    logic [4:0]       rd;
    logic             we;
    logic [63:0]      data;
    logic [63:0]      tval;
  } trace_rec_t;

  typedef enum logic [0:0] {
    ST_RUN  = 1'b0,
    ST_LOST = 1'b1
  } sched_state_e;

endpackage

// File: rtl/commit_trace_sched_if.sv
// Valid/ready stream carrying one trace record per transfer from the
// scheduler (master) to the trace sink (slave).
interface commit_trace_sched_if;
  import trace_pkg::*;

  logic       trace_valid_o;
  logic       trace_ready_i;
  trace_rec_t trace_rec_o;

  modport master (
    output trace_valid_o,
    output trace_rec_o,
    input  trace_ready_i
  );

  modport slave (
    input  trace_valid_o,
    input  trace_rec_o,
    output trace_ready_i
  );

endinterface

// File: rtl/commit_trace_sched_fifo.sv
// Circular record buffer with a multi-record write port (up to MAXW records
// land in consecutive wrapped slots per cycle) and a single FWFT read port.
// The writer guarantees it never pushes more than the free space it saw at
// cycle start, so no overflow protection is needed here.
module trace_mpush_fifo
  import trace_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int MAXW  = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       clear,
  input  logic [$clog2(MAXW+1)-1:0]  wr_cnt,
  input  trace_rec_t                 wr_data [MAXW],
  input  logic                       rd_en,
  output trace_rec_t                 rd_data,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int NW = $clog2(MAXW + 1);

  trace_rec_t      mem_r [DEPTH];
  logic [AW-1:0]   wr_ptr_r;
  logic [AW-1:0]   rd_ptr_r;
  logic [CW-1:0]   count_r;
  logic            pop_s;

  assign pop_s   = rd_en && (count_r != '0);
  assign rd_data = mem_r[rd_ptr_r];
  assign count   = count_r;

  // Storage array: write the first wr_cnt records into consecutive slots
  always_ff @(posedge clk_i) begin
    for (int k = 0; k < MAXW; k++) begin
      if (NW'(k) < wr_cnt) begin
        mem_r[wr_ptr_r + AW'(k)] <= wr_data[k];
      end
    end
  end

  // Pointers and occupancy; clear wins over any write or read in the same cycle
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else if (clear) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      wr_ptr_r <= wr_ptr_r + AW'(wr_cnt);
      rd_ptr_r <= rd_ptr_r + AW'(pop_s);
      count_r  <= count_r + CW'(wr_cnt) - CW'(pop_s);
    end
  end

endmodule

// File: rtl/commit_trace_sched.sv
// Commit-trace scheduler: serialises per-cycle commits and exceptions into
// program-ordered records, never stalls the commit stage, drops whole cycles
// when the buffer lacks room and marks each loss with a GAP record.
module commit_trace_sched
  import trace_pkg::*;
#(
  parameter int NR_COMMIT_PORTS = 2,
  parameter int DEPTH           = 8,
  parameter int VLEN            = trace_pkg::VLEN,
  parameter int SEQ_W           = trace_pkg::SEQ_W
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic                            enable_i,
  input  logic                            clear_i,
  input  logic [NR_COMMIT_PORTS-1:0]      commit_ack_i,
  input  logic [NR_COMMIT_PORTS*VLEN-1:0] commit_pc_i,
  input  logic [NR_COMMIT_PORTS*32-1:0]   commit_instr_i,
  input  logic [NR_COMMIT_PORTS*5-1:0]    commit_rd_i,
  input  logic [NR_COMMIT_PORTS-1:0]      commit_we_i,
  input  logic [NR_COMMIT_PORTS*64-1:0]   commit_wdata_i,
  input  logic                            ex_valid_i,
  input  logic [VLEN-1:0]                 ex_pc_i,
  input  logic [63:0]                     ex_cause_i,
  input  logic [63:0]                     ex_tval_i,
  input  logic [1:0]                      priv_lvl_i,
  input  logic                            debug_mode_i,
  commit_trace_sched_if.master            trace,
  output logic [31:0]                     drop_cnt_o,
  output logic                            overflow_o
);

  localparam int MAXW = NR_COMMIT_PORTS + 2;
  localparam int CW   = $clog2(DEPTH + 1);
  localparam int NW   = $clog2(MAXW + 1);

  sched_state_e     state_r;
  sched_state_e     next_state_s;
  logic [SEQ_W-1:0] seq_r;
  logic [31:0]      drop_cnt_r;
  logic             overflow_r;

  logic [CW-1:0]    count_s;
  logic [CW-1:0]    free_s;
  logic [NW-1:0]    n_s;
  logic [NW-1:0]    wr_cnt_s;
  logic             ex_take_s;
  logic             do_push_s;
  logic             gap_s;
  logic             drop_s;
  logic             pop_s;
  logic [32:0]      drop_sum_s;
  trace_rec_t       push_rec_s [MAXW];
  trace_rec_t       head_rec_s;

  // Space is judged against occupancy at cycle start; a same-cycle pop is not credited
  assign free_s = CW'(DEPTH) - count_s;
  assign pop_s  = (count_s != '0) && trace.trace_ready_i;

  assign trace.trace_valid_o = (count_s != '0);
  assign trace.trace_rec_o   = head_rec_s;
  assign drop_cnt_o          = drop_cnt_r;
  assign overflow_o          = overflow_r;

  // Size of this cycle's incoming set; a debug-mode breakpoint is not traced at all
  always_comb begin
    ex_take_s = 1'b0;
    n_s       = '0;
    if (enable_i) begin
      ex_take_s = ex_valid_i && !(debug_mode_i && (ex_cause_i == BREAKPOINT_CAUSE));
      for (int i = 0; i < NR_COMMIT_PORTS; i++) begin
        n_s = n_s + NW'(commit_ack_i[i]);
      end
      n_s = n_s + NW'(ex_take_s);
    end else begin
      ex_take_s = 1'b0;
      n_s       = '0;
    end
  end

  // All-or-nothing push decision; leaving LOST needs one extra slot for the GAP marker
  always_comb begin
    do_push_s    = 1'b0;
    gap_s        = 1'b0;
    drop_s       = 1'b0;
    next_state_s = state_r;
    case (state_r)
      ST_RUN: begin
        if (free_s >= CW'(n_s)) begin
          do_push_s = 1'b1;
        end else begin
          drop_s       = 1'b1;
          next_state_s = ST_LOST;
        end
      end
      ST_LOST: begin
        if (free_s >= (CW'(n_s) + CW'(1))) begin
          do_push_s    = 1'b1;
          gap_s        = 1'b1;
          next_state_s = ST_RUN;
        end else begin
          drop_s = 1'b1;
        end
      end
      default: begin
        next_state_s = ST_RUN;
      end
    endcase
  end

  // Record formatting: optional GAP first, then commits by ascending port, then exception
  always_comb begin
    int pos;
    for (int k = 0; k < MAXW; k++) begin
      push_rec_s[k] = '0;
    end
    pos = 0;
    if (gap_s) begin
      push_rec_s[0].kind = GAP;
      push_rec_s[0].data = 64'(drop_cnt_r);
      pos = 1;
    end else begin
      pos = 0;
    end
    for (int i = 0; i < NR_COMMIT_PORTS; i++) begin
      if (enable_i && commit_ack_i[i]) begin
        push_rec_s[pos].kind  = COMMIT;
        push_rec_s[pos].pc    = commit_pc_i[i*VLEN +: VLEN];
        push_rec_s[pos].instr = commit_instr_i[i*32 +: 32];
        push_rec_s[pos].rd    = commit_rd_i[i*5 +: 5];
        push_rec_s[pos].we    = commit_we_i[i];
        push_rec_s[pos].data  = commit_wdata_i[i*64 +: 64];
        pos = pos + 1;
      end else begin
        pos = pos;
      end
    end
    if (ex_take_s) begin
      push_rec_s[pos].kind = EXCEPTION;
      push_rec_s[pos].pc   = ex_pc_i;
      push_rec_s[pos].data = ex_cause_i;
      push_rec_s[pos].tval = ex_tval_i;
      pos = pos + 1;
    end else begin
      pos = pos;
    end
    for (int k = 0; k < MAXW; k++) begin
      push_rec_s[k].seq  = seq_r + SEQ_W'(k);
      push_rec_s[k].priv = priv_lvl_i;
      push_rec_s[k].dbg  = debug_mode_i;
    end
    if (do_push_s) begin
      wr_cnt_s = NW'(pos);
    end else begin
      wr_cnt_s = '0;
    end
  end

  assign drop_sum_s = {1'b0, drop_cnt_r} + 33'(n_s);

  // Scheduler state, sequence counter and saturating loss accounting
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r    <= ST_RUN;
      seq_r      <= '0;
      drop_cnt_r <= 32'd0;
      overflow_r <= 1'b0;
    end else if (clear_i) begin
      state_r    <= ST_RUN;
      seq_r      <= '0;
      drop_cnt_r <= 32'd0;
      overflow_r <= 1'b0;
    end else begin
      state_r <= next_state_s;
      seq_r   <= seq_r + SEQ_W'(wr_cnt_s);
      if (drop_s && (n_s != '0)) begin
        overflow_r <= 1'b1;
        drop_cnt_r <= drop_sum_s[32] ? 32'hFFFF_FFFF : drop_sum_s[31:0];
      end else begin
        overflow_r <= overflow_r;
        drop_cnt_r <= drop_cnt_r;
      end
    end
  end

  trace_mpush_fifo #(
    .DEPTH (DEPTH),
    .MAXW  (MAXW)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clear   (clear_i),
    .wr_cnt  (wr_cnt_s),
    .wr_data (push_rec_s),
    .rd_en   (pop_s),
    .rd_data (head_rec_s),
    .count   (count_s)
  );

endmodule
